f_regfile_mp: RTL

F_REGFILE_MP -- requirements
Module: f_regfile_mp

---
 rtl/f_regfile_pkg.sv | 32 +++
 rtl/f_scoreboard.sv | 45 ++++
 rtl/f_regfile_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/f_regfile_pkg.sv
// Shared types for the floating-point register file: rounding modes,
// exception-flag bit positions and CSR field selectors.
package f_regfile_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  typedef enum logic [1:0] {
    CSR_NONE   = 2'b00,
    CSR_FFLAGS = 2'b01,
    CSR_FRM    = 2'b10,
    CSR_FCSR   = 2'b11
  } csr_sel_e;

  // Encodings 101 and 110 are reserved in every context.
  function automatic logic rm_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110);
  endfunction

endpackage

// File: rtl/f_scoreboard.sv
// Pending-write tracking for the f registers and the resulting issue stall.
module f_scoreboard
  import f_regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NRP  = 3,
  parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRP-1:0][AW-1:0]  rs_addr,
  input  logic                    wen,
  input  logic [AW-1:0]           rd,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic [NREG-1:0]         pending,
  output logic                    stall
);

  // A new issue to an index beats a same-cycle writeback to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (issue_valid && (issue_rd == AW'(i)))
          pending[i] <= 1'b1;
        else if (wen && (rd == AW'(i)))
          pending[i] <= 1'b0;
      end
    end
  end

  // A writeback landing this cycle resolves the hazard through the bypass.
  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      if (pending[rs_addr[p]] && !(wen && (rd == rs_addr[p])))
        stall = 1'b1;
    end
    if (issue_valid && pending[issue_rd] && !(wen && (rd == issue_rd)))
      stall = 1'b1;
  end

endmodule

// File: rtl/f_regfile_mp.sv
// Multi-port floating-point register file with write-through bypass,
// pending-write scoreboard and fcsr (fflags/frm) with rounding-mode resolve.
module f_regfile_mp
  import f_regfile_pkg::*;
#(
  parameter int FLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 3,
  parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRP-1:0][AW-1:0]    rs_addr,
  output logic [NRP-1:0][FLEN-1:0]  rs_data,
  input  logic                      wen,
  input  logic [AW-1:0]             rd,
  input  logic [FLEN-1:0]           w_data,
  input  logic                      flags_valid,
  input  logic [4:0]                flags,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rd,
  input  logic                      csr_wen,
  input  logic [1:0]                csr_sel,
  input  logic [7:0]                csr_wdata,
  output logic [7:0]                csr_rdata,
  input  logic [2:0]                inst_rm,
  output logic [2:0]                rm_eff,
  output logic                      rm_illegal,
  output logic                      stall
);

  logic [FLEN-1:0] regs [NREG];
  logic [2:0]      frm, frm_next;
  logic [4:0]      fflags, fflags_next;
  logic [NREG-1:0] pending;
  logic            csr_hits_flags;

  // issue_valid and wen carry no ready: the issuer must hold back while stall=1.
  f_scoreboard #(.NREG(NREG), .NRP(NRP), .AW(AW)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .wen         (wen),
    .rd          (rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pending     (pending),
    .stall       (stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[rd] <= w_data;
    end
  end

  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      rs_data[p] = (wen && (rd == rs_addr[p])) ? w_data : regs[rs_addr[p]];
    end
  end

  assign csr_hits_flags = csr_wen &&
                          ((csr_sel == CSR_FFLAGS) || (csr_sel == CSR_FCSR));

  // FPU flags OR on top of any CSR write so a same-cycle exception is never lost.
  always_comb begin
    fflags_next = (csr_hits_flags ? csr_wdata[4:0] : fflags) |
                  (flags_valid ? flags : 5'b0);
    frm_next = frm;
    if (csr_wen && (csr_sel == CSR_FCSR))
      frm_next = csr_wdata[7:5];
    else if (csr_wen && (csr_sel == CSR_FRM))
      frm_next = csr_wdata[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
      frm    <= '0;
    end else begin
      fflags <= fflags_next;
      frm    <= frm_next;
    end
  end

  assign csr_rdata  = {frm, fflags};
  assign rm_eff     = (inst_rm == RM_DYN) ? frm : inst_rm;
  assign rm_illegal = rm_reserved(inst_rm) ||
                      ((inst_rm == RM_DYN) && (rm_reserved(frm) || (frm == RM_DYN)));

endmodule
